even_count_checker: RTL and testbench

//   Receive-side monitor for the even up/down binary counter stream.

---
 rtl/even_count_checker_if.sv | 25 ++
 rtl/even_count_checker.sv | 119 +++++++++++
 tb/tb_even_count_checker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/even_count_checker_if.sv
// Counter-stream bus between an even up/down counter source and its receive-side checker.
// Carries the sampled count word/direction and the checker's status outputs.
interface even_count_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
);
    logic             sample_valid;
    logic [WIDTH-1:0] count_in;
    logic             dir_in;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] expected;
    logic             odd_seen;

    modport master (
        output sample_valid, count_in, dir_in,
        input  locked, err_pulse, err_count, expected, odd_seen
    );

    modport slave (
        input  sample_valid, count_in, dir_in,
        output locked, err_pulse, err_count, expected, odd_seen
    );
endinterface

// File: rtl/even_count_checker.sv
// Receive-side monitor for an even up/down counter stream: predicts, locks, counts errors.
// Optional macro ODD_CHECK_EN: odd words are forced mismatches and the prediction coasts.
module even_count_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STEP     = 2,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    even_count_checker_if.slave  bus
);
    localparam int unsigned GR_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [GR_W-1:0]  LOCK_W = GR_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t           r_state;
    logic [GR_W-1:0]  r_good_run;
    logic [WIDTH-1:0] r_expected;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;
    logic             r_odd_seen;

    logic [WIDTH-1:0] w_reload;
    logic [WIDTH-1:0] w_next_expected;
    logic             w_match;
    logic [GR_W-1:0]  w_run_inc;
    logic             w_run_done;
    logic             w_err_sat;

    // Reload prediction from the current sample; arithmetic wraps modulo 2**WIDTH.
    assign w_reload = bus.dir_in ? WIDTH'(bus.count_in + STEP_W)
                                 : WIDTH'(bus.count_in - STEP_W);

`ifdef ODD_CHECK_EN
    logic             w_is_odd;
    logic [WIDTH-1:0] w_coast;

    assign w_is_odd        = bus.count_in[0];
    assign w_coast         = bus.dir_in ? WIDTH'(r_expected + STEP_W)
                                        : WIDTH'(r_expected - STEP_W);
    assign w_match         = (bus.count_in == r_expected) && !w_is_odd;
    assign w_next_expected = w_is_odd ? w_coast : w_reload;
`else
    assign w_match         = (bus.count_in == r_expected);
    assign w_next_expected = w_reload;
`endif

    assign w_run_inc  = GR_W'(r_good_run + GR_W'(1));
    assign w_run_done = (w_run_inc == LOCK_W);
    assign w_err_sat  = &r_err_count;

    // Lock FSM with registered status outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_good_run  <= '0;
            r_expected  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_odd_seen  <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (bus.sample_valid) begin
                r_expected <= w_next_expected;
`ifdef ODD_CHECK_EN
                if (w_is_odd) r_odd_seen <= 1'b1;
`endif
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_ACQUIRE;
                        r_good_run <= '0;
                    end
                    S_ACQUIRE: begin
                        if (w_match) begin
                            if (w_run_done) begin
                                r_state    <= S_LOCKED;
                                r_locked   <= 1'b1;
                                r_good_run <= '0;
                            end else begin
                                r_good_run <= w_run_inc;
                            end
                        end else begin
                            r_good_run <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (!w_match) begin
                            r_err_pulse <= 1'b1;
                            if (!w_err_sat) r_err_count <= ERR_W'(r_err_count + ERR_W'(1));
                            r_state    <= S_ACQUIRE;
                            r_locked   <= 1'b0;
                            r_good_run <= '0;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_locked   <= 1'b0;
                        r_good_run <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
    assign bus.expected  = r_expected;
    assign bus.odd_seen  = r_odd_seen;
endmodule

// File: tb/tb_even_count_checker.sv
// Directed bench for even_count_checker: default instance plus an ERR_W=2 instance for saturation.
// Both instances see identical stimulus; expectations are hand-computed.
module tb_even_count_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    even_count_checker_if #(.WIDTH(4), .ERR_W(8)) bus  ();
    even_count_checker_if #(.WIDTH(4), .ERR_W(2)) bus2 ();

    even_count_checker #(.WIDTH(4), .STEP(2), .LOCK_CNT(2), .ERR_W(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    even_count_checker #(.WIDTH(4), .STEP(2), .LOCK_CNT(2), .ERR_W(2)) dut2 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic d);
        bus.sample_valid  = v;  bus.count_in  = c;  bus.dir_in  = d;
        bus2.sample_valid = v;  bus2.count_in = c;  bus2.dir_in = d;
    endtask

    // Present one valid sample, then settle just after the capturing edge.
    task automatic smp(input logic [3:0] c, input logic d);
        @(negedge clk);
        drive(1'b1, c, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        drive(1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"},   32'(bus.locked),    32'd0);
        chk({tag, "_pulse"},    32'(bus.err_pulse), 32'd0);
        chk({tag, "_errcnt"},   32'(bus.err_count), 32'd0);
        chk({tag, "_expected"}, 32'(bus.expected),  32'd0);
        chk({tag, "_odd"},      32'(bus.odd_seen),  32'd0);
        chk({tag, "_errcnt2"},  32'(bus2.err_count), 32'd0);
    endtask

    initial begin
        logic [3:0] e;
        logic [3:0] x;
        drive(1'b0, 4'h0, 1'b0);

        // Reset for two clocks while a valid sample is presented.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 4'h6, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b0);

        // Up stream 0,2,4,6: lock after the third sample.
        smp(4'h0, 1'b1);
        chk("s0_locked", 32'(bus.locked), 32'd0);
        chk("s0_exp", 32'(bus.expected), 32'h2);
        smp(4'h2, 1'b1);
        chk("s2_locked", 32'(bus.locked), 32'd0);
        smp(4'h4, 1'b1);
        chk("s4_locked", 32'(bus.locked), 32'd1);
        chk("s4_exp", 32'(bus.expected), 32'h6);
        smp(4'h6, 1'b1);
        chk("s6_locked", 32'(bus.locked), 32'd1);
        chk("s6_errcnt", 32'(bus.err_count), 32'd0);
        chk("s6_exp", 32'(bus.expected), 32'h8);
        idle();
        chk("idle_locked", 32'(bus.locked), 32'd1);
        chk("idle_exp", 32'(bus.expected), 32'h8);
        chk("idle_pulse", 32'(bus.err_pulse), 32'd0);

        // Glitch while locked, then relock.
        smp(4'h8, 1'b1);
        chk("g8_pulse", 32'(bus.err_pulse), 32'd0);
        smp(4'h4, 1'b1);
        chk("glitch_pulse", 32'(bus.err_pulse), 32'd1);
        chk("glitch_errcnt", 32'(bus.err_count), 32'd1);
        chk("glitch_locked", 32'(bus.locked), 32'd0);
        chk("glitch_exp", 32'(bus.expected), 32'h6);
        idle();
        chk("glitch_pulse_clr", 32'(bus.err_pulse), 32'd0);
        smp(4'h6, 1'b1);
        chk("re6_locked", 32'(bus.locked), 32'd0);
        chk("re6_pulse", 32'(bus.err_pulse), 32'd0);
        smp(4'h8, 1'b1);
        chk("re8_locked", 32'(bus.locked), 32'd1);
        chk("re8_errcnt", 32'(bus.err_count), 32'd1);

        // Wrap upward through 0, reverse at 2, wrap downward through 0.
        smp(4'hA, 1'b1);
        smp(4'hC, 1'b1);
        smp(4'hE, 1'b1);
        chk("wrapup_exp", 32'(bus.expected), 32'h0);
        smp(4'h0, 1'b1);
        chk("wrapup_pulse", 32'(bus.err_pulse), 32'd0);
        smp(4'h2, 1'b0);
        chk("rev_exp", 32'(bus.expected), 32'h0);
        smp(4'h0, 1'b0);
        chk("wrapdn_exp", 32'(bus.expected), 32'hE);
        smp(4'hE, 1'b0);
        chk("wrapdn_pulse", 32'(bus.err_pulse), 32'd0);
        smp(4'hC, 1'b0);
        chk("wrap_locked", 32'(bus.locked), 32'd1);
        chk("wrap_errcnt", 32'(bus.err_count), 32'd1);
        chk("wrap_exp", 32'(bus.expected), 32'hA);

        // Five locked mismatches with relock between; ERR_W=2 instance saturates at 3.
        e = 4'hA;
        for (int i = 0; i < 5; i++) begin
            x = e + 4'h8;
            smp(x, 1'b0);
            chk("sat_pulse2", 32'(bus2.err_pulse), 32'd1);
            chk("sat_errcnt2", 32'(bus2.err_count), (i >= 1) ? 32'd3 : 32'd2);
            chk("sat_errcnt", 32'(bus.err_count), 32'(i + 2));
            x = x - 4'h2;
            smp(x, 1'b0);
            x = x - 4'h2;
            smp(x, 1'b0);
            chk("sat_relock2", 32'(bus2.locked), 32'd1);
            e = x - 4'h2;
        end
        chk("sat_final2", 32'(bus2.err_count), 32'd3);
        chk("sat_final", 32'(bus.err_count), 32'd6);

        // Reset mid-stream while locked.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, e, 1'b0);
        @(posedge clk);
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b0);
        smp(4'h0, 1'b1);
        smp(4'h2, 1'b1);
        chk("relock2_locked", 32'(bus.locked), 32'd0);
        smp(4'h4, 1'b1);
        chk("relock3_locked", 32'(bus.locked), 32'd1);
        chk("relock3_exp", 32'(bus.expected), 32'h6);

        // Odd word injected while locked.
        smp(4'h5, 1'b1);
        chk("odd_pulse", 32'(bus.err_pulse), 32'd1);
        chk("odd_errcnt", 32'(bus.err_count), 32'd1);
        chk("odd_locked", 32'(bus.locked), 32'd0);
`ifdef ODD_CHECK_EN
        chk("odd_seen", 32'(bus.odd_seen), 32'd1);
        chk("odd_exp", 32'(bus.expected), 32'h8);
        smp(4'h8, 1'b1);
        chk("odd_next_pulse", 32'(bus.err_pulse), 32'd0);
        chk("odd_next_exp", 32'(bus.expected), 32'hA);
        chk("odd_next_errcnt", 32'(bus.err_count), 32'd1);
`else
        chk("odd_seen", 32'(bus.odd_seen), 32'd0);
        chk("odd_exp", 32'(bus.expected), 32'h7);
        smp(4'h7, 1'b1);
        chk("odd_next_pulse", 32'(bus.err_pulse), 32'd0);
        chk("odd_next_exp", 32'(bus.expected), 32'h9);
        chk("odd_next_seen", 32'(bus.odd_seen), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
